// File: rtl/alu_seq_pkg.sv
// Shared encodings and operand helpers for the byte-serial add/sub sequencer.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        OP_ADD8  = 2'b00,
        OP_SUB8  = 2'b01,
        OP_ADD16 = 2'b10,
        OP_SUB16 = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LO_RUN = 3'd1,
        ST_GAP    = 3'd2,
        ST_HI_RUN = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    function automatic logic is_sub(input logic [1:0] op);
        return op[0];
    endfunction

    function automatic logic is_16(input logic [1:0] op);
        return op[1];
    endfunction

    function automatic logic [7:0] desired_byte(input logic sub, input logic [7:0] b);
        return sub ? ~b : b;
    endfunction

    // The adder XORs its b input with c_in, so pre-XOR to make it see the desired byte.
    function automatic logic [7:0] drive_byte(input logic sub, input logic [7:0] b, input logic c_in);
        return desired_byte(sub, b) ^ {8{c_in}};
    endfunction

endpackage

// File: rtl/alu_flag_calc.sv
// Combinational carry/zero/negative/overflow for an 8- or 16-bit add/sub result.
module alu_flag_calc
    import alu_seq_pkg::*;
(
    input  logic [15:0] result,
    input  logic [15:0] a,
    input  logic [15:0] b_eff,
    input  logic        c_out,
    input  logic        wide,
    output logic        carry,
    output logic        zero,
    output logic        negative,
    output logic        overflow
);

    logic a_msb_s;
    logic b_msb_s;
    logic r_msb_s;

    // Select sign bits and zero test according to the operation width.
    always_comb begin
        carry = c_out;
        if (wide) begin
            a_msb_s = a[15];
            b_msb_s = b_eff[15];
            r_msb_s = result[15];
            zero    = (result == 16'h0000);
        end else begin
            a_msb_s = a[7];
            b_msb_s = b_eff[7];
            r_msb_s = result[7];
            zero    = (result[7:0] == 8'h00);
        end
        negative = r_msb_s;
        overflow = (a_msb_s == b_msb_s) && (r_msb_s != a_msb_s);
    end

endmodule

// File: rtl/alu_add_sequencer.sv
// Drives an 8-bit en/ready adder one byte per pass to perform 8/16-bit ADD/SUB,
// chaining carry between passes and returning registered result, flags and a done pulse.
module alu_add_sequencer
    import alu_seq_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15,
    parameter int GAP_CYCLES     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [15:0] result,
    output logic        carry,
    output logic        zero,
    output logic        negative,
    output logic        overflow,
    output logic        adder_en,
    output logic [7:0]  adder_a,
    output logic [7:0]  adder_b,
    output logic        adder_c_in,
    input  logic [7:0]  adder_out,
    input  logic        adder_c_out,
    input  logic        adder_ready
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    state_e      state_r, state_nxt_s;
    op_e         op_r, op_nxt_s;
    logic [15:0] a_r, a_nxt_s, b_r, b_nxt_s;
    logic [7:0]  lo_r, lo_nxt_s;
    logic        c_lo_r, c_lo_nxt_s;
    logic [7:0]  cnt_r, cnt_nxt_s;
    logic        busy_r, busy_nxt_s, done_r, done_nxt_s, timeout_r, timeout_nxt_s;
    logic        en_r, en_nxt_s, c_in_r, c_in_nxt_s;
    logic [7:0]  adder_a_r, adder_a_nxt_s, adder_b_r, adder_b_nxt_s;
    logic [15:0] result_r;
    logic        carry_r, zero_r, negative_r, overflow_r;
    logic        res_load_s;
    logic [15:0] res_val_s;
    logic        fin_carry_s;
    logic [15:0] b_eff_s;
    logic        flag_carry_s, flag_zero_s, flag_negative_s, flag_overflow_s;
    logic        ready_s;

    assign ready_s = en_r && adder_ready;
    assign b_eff_s = {desired_byte(is_sub(op_r), b_r[15:8]), desired_byte(is_sub(op_r), b_r[7:0])};

    alu_flag_calc u_flags (
        .result   (res_val_s),
        .a        (a_r),
        .b_eff    (b_eff_s),
        .c_out    (fin_carry_s),
        .wide     (is_16(op_r)),
        .carry    (flag_carry_s),
        .zero     (flag_zero_s),
        .negative (flag_negative_s),
        .overflow (flag_overflow_s)
    );

    // Next-state, next-output and result-capture decode.
    always_comb begin
        state_nxt_s   = state_r;
        op_nxt_s      = op_r;
        a_nxt_s       = a_r;
        b_nxt_s       = b_r;
        lo_nxt_s      = lo_r;
        c_lo_nxt_s    = c_lo_r;
        cnt_nxt_s     = cnt_r;
        busy_nxt_s    = busy_r;
        done_nxt_s    = 1'b0;
        timeout_nxt_s = 1'b0;
        en_nxt_s      = en_r;
        c_in_nxt_s    = c_in_r;
        adder_a_nxt_s = adder_a_r;
        adder_b_nxt_s = adder_b_r;
        res_load_s    = 1'b0;
        res_val_s     = result_r;
        fin_carry_s   = carry_r;
        case (state_r)
            ST_IDLE: begin
                busy_nxt_s = 1'b0;
                if (start) begin
                    state_nxt_s   = ST_LO_RUN;
                    op_nxt_s      = op_e'(op);
                    a_nxt_s       = a;
                    b_nxt_s       = b;
                    busy_nxt_s    = 1'b1;
                    cnt_nxt_s     = 8'd0;
                    en_nxt_s      = 1'b1;
                    c_in_nxt_s    = is_sub(op);
                    adder_a_nxt_s = a[7:0];
                    adder_b_nxt_s = drive_byte(is_sub(op), b[7:0], is_sub(op));
                end else begin
                    en_nxt_s = 1'b0;
                end
            end
            ST_LO_RUN, ST_HI_RUN: begin
                if (ready_s) begin
                    en_nxt_s = 1'b0;
                    if (state_r == ST_LO_RUN && is_16(op_r)) begin
                        state_nxt_s = ST_GAP;
                        lo_nxt_s    = adder_out;
                        c_lo_nxt_s  = adder_c_out;
                        cnt_nxt_s   = 8'd0;
                    end else begin
                        state_nxt_s = ST_FINISH;
                        done_nxt_s  = 1'b1;
                        res_load_s  = 1'b1;
                        fin_carry_s = adder_c_out;
                        res_val_s   = (state_r == ST_HI_RUN) ? {adder_out, lo_r} : {8'h00, adder_out};
                    end
                end else if (cnt_r == TMO_LAST) begin
                    en_nxt_s      = 1'b0;
                    state_nxt_s   = ST_FINISH;
                    done_nxt_s    = 1'b1;
                    timeout_nxt_s = 1'b1;
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_nxt_s   = ST_HI_RUN;
                    cnt_nxt_s     = 8'd0;
                    en_nxt_s      = 1'b1;
                    c_in_nxt_s    = c_lo_r;
                    adder_a_nxt_s = a_r[15:8];
                    adder_b_nxt_s = drive_byte(is_sub(op_r), b_r[15:8], c_lo_r);
                end else begin
                    cnt_nxt_s = cnt_r + 8'd1;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
                en_nxt_s    = 1'b0;
            end
            default: begin
                state_nxt_s = ST_IDLE;
                busy_nxt_s  = 1'b0;
                en_nxt_s    = 1'b0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset aborts any operation silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_IDLE;
            op_r       <= OP_ADD8;
            a_r        <= 16'h0000;
            b_r        <= 16'h0000;
            lo_r       <= 8'h00;
            c_lo_r     <= 1'b0;
            cnt_r      <= 8'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            timeout_r  <= 1'b0;
            en_r       <= 1'b0;
            c_in_r     <= 1'b0;
            adder_a_r  <= 8'h00;
            adder_b_r  <= 8'h00;
            result_r   <= 16'h0000;
            carry_r    <= 1'b0;
            zero_r     <= 1'b0;
            negative_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            op_r      <= op_nxt_s;
            a_r       <= a_nxt_s;
            b_r       <= b_nxt_s;
            lo_r      <= lo_nxt_s;
            c_lo_r    <= c_lo_nxt_s;
            cnt_r     <= cnt_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
            timeout_r <= timeout_nxt_s;
            en_r      <= en_nxt_s;
            c_in_r    <= c_in_nxt_s;
            adder_a_r <= adder_a_nxt_s;
            adder_b_r <= adder_b_nxt_s;
            if (res_load_s) begin
                result_r   <= res_val_s;
                carry_r    <= flag_carry_s;
                zero_r     <= flag_zero_s;
                negative_r <= flag_negative_s;
                overflow_r <= flag_overflow_s;
            end
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign timeout    = timeout_r;
    assign result     = result_r;
    assign carry      = carry_r;
    assign zero       = zero_r;
    assign negative   = negative_r;
    assign overflow   = overflow_r;
    assign adder_en   = en_r;
    assign adder_a    = adder_a_r;
    assign adder_b    = adder_b_r;
    assign adder_c_in = c_in_r;

endmodule

// File: tb/tb_alu_add_sequencer.sv
// Scoreboard bench for alu_add_sequencer with a behavioural en/ready adder of variable latency.
module tb_alu_add_sequencer;

    typedef struct packed {
        logic [15:0] result;
        logic        carry;
        logic        zero;
        logic        negative;
        logic        overflow;
        logic        timeout;
    } exp_t;

    logic        clk, reset, start;
    logic [1:0]  op;
    logic [15:0] a, b, result;
    logic        busy, done, timeout, carry, zero, negative, overflow;
    logic        adder_en, adder_c_in, adder_c_out, adder_ready;
    logic [7:0]  adder_a, adder_b, adder_out;

    int   adder_lat;
    bit   adder_stall;
    int   acnt;
    logic [8:0] asum;

    exp_t sb[$];
    exp_t last_exp, got, want;
    int   n_vec, n_err;

    alu_add_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .timeout(timeout), .result(result),
        .carry(carry), .zero(zero), .negative(negative), .overflow(overflow),
        .adder_en(adder_en), .adder_a(adder_a), .adder_b(adder_b), .adder_c_in(adder_c_in),
        .adder_out(adder_out), .adder_c_out(adder_c_out), .adder_ready(adder_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural adder: ready after adder_lat cycles of en, outputs X otherwise.
    always @(posedge clk) acnt <= adder_en ? acnt + 1 : 0;
    assign asum        = {1'b0, adder_a} + {1'b0, adder_b ^ {8{adder_c_in}}} + {8'h00, adder_c_in};
    assign adder_ready = adder_en && !adder_stall && (acnt >= adder_lat);
    assign adder_out   = adder_ready ? asum[7:0] : 8'hxx;
    assign adder_c_out = adder_ready ? asum[8] : 1'bx;

    function automatic exp_t model(input logic [1:0] m_op, input logic [15:0] m_a, input logic [15:0] m_b);
        exp_t e;
        logic [15:0] bx;
        logic [16:0] w;
        logic [8:0]  n;
        e  = '0;
        bx = m_op[0] ? ~m_b : m_b;
        if (m_op[1]) begin
            w = {1'b0, m_a} + {1'b0, bx} + {16'd0, m_op[0]};
            e.result = w[15:0]; e.carry = w[16]; e.negative = w[15];
            e.overflow = (m_a[15] == bx[15]) && (w[15] != m_a[15]);
        end else begin
            n = {1'b0, m_a[7:0]} + {1'b0, bx[7:0]} + {8'd0, m_op[0]};
            e.result = {8'h00, n[7:0]}; e.carry = n[8]; e.negative = n[7];
            e.overflow = (m_a[7] == bx[7]) && (n[7] != m_a[7]);
        end
        e.zero = (e.result == 16'h0000);
        return e;
    endfunction

    // mode 0: normal op, 1: expect timeout, 2: no expectation
    task automatic issue(input logic [1:0] t_op, input logic [15:0] t_a, input logic [15:0] t_b, input int mode);
        exp_t e;
        if (mode == 0) begin
            e = model(t_op, t_a, t_b);
            last_exp = e;
            sb.push_back(e);
        end else if (mode == 1) begin
            e = last_exp;
            e.timeout = 1'b1;
            sb.push_back(e);
        end
        start = 1'b1; op = t_op; a = t_a; b = t_b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic await_done(input int budget, output bit seen, output int cycles, output int gap_low,
                              output logic [7:0] last_b, output logic last_cin);
        int phase;
        seen = 1'b0; cycles = 0; gap_low = 0; phase = 1;
        last_b = adder_b; last_cin = adder_c_in;
        while (!seen && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (done) begin
                seen = 1'b1;
            end else if (adder_en) begin
                last_b = adder_b; last_cin = adder_c_in;
                if (phase == 2) phase = 3;
            end else if (phase != 3) begin
                phase = 2;
                gap_low++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 2'b00; a = 16'h0000; b = 16'h0000;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, timeout, adder_en, adder_c_in, adder_a, adder_b, result, carry, zero, negative, overflow} !== 41'd0) begin
            n_err++;
            $display("FAIL reset_state: got busy=%b done=%b tmo=%b en=%b cin=%b a=%h b=%h res=%h flags=%b%b%b%b, want all 0",
                     busy, done, timeout, adder_en, adder_c_in, adder_a, adder_b, result, carry, zero, negative, overflow);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add8();
        bit seen; int cyc, gl; logic [7:0] lb; logic lc;
        adder_lat = 2;
        issue(2'b00, 16'd100, 16'd27, 0);
        n_vec++;
        if (busy !== 1'b1 || adder_en !== 1'b1) begin n_err++; $display("FAIL add8_busy: got busy=%b en=%b want 1 1", busy, adder_en); end
        await_done(50, seen, cyc, gl, lb, lc);
        n_vec++;
        if (!seen) begin n_err++; $display("FAIL add8_done: no done within 50 cycles"); end
        else begin
            if (cyc !== 3) begin n_err++; $display("FAIL add8_latency: got %0d want 3", cyc); end
            got = {result, carry, zero, negative, overflow, timeout}; want = sb.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL add8_result: got %h want %h", got, want); end
            n_vec++;
            if (busy !== 1'b1) begin n_err++; $display("FAIL add8_busy_at_done: got %b want 1", busy); end
        end
        @(negedge clk);
        n_vec++;
        if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL add8_pulse: got done=%b busy=%b want 0 0", done, busy); end
    endtask

    task automatic test_sub8();
        logic [15:0] ta[2] = '{16'h0005, 16'h0080};
        logic [15:0] tb[2] = '{16'h0005, 16'h0001};
        bit seen; int cyc, gl; logic [7:0] lb; logic lc;
        adder_lat = 1;
        for (int i = 0; i < 2; i++) begin
            issue(2'b01, ta[i], tb[i], 0);
            await_done(50, seen, cyc, gl, lb, lc);
            n_vec++;
            if (!seen) begin n_err++; $display("FAIL sub8_done: case %0d no done", i); end
            else begin
                got = {result, carry, zero, negative, overflow, timeout}; want = sb.pop_front();
                if (got !== want) begin n_err++; $display("FAIL sub8_result: case %0d got %h want %h", i, got, want); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_add16();
        bit seen; int cyc, gl; logic [7:0] lb; logic lc;
        adder_lat = 2;
        issue(2'b10, 16'h00FF, 16'h0001, 0);
        await_done(80, seen, cyc, gl, lb, lc);
        n_vec++;
        if (!seen) begin n_err++; $display("FAIL add16_done: no done"); end
        else begin
            if (gl !== 2) begin n_err++; $display("FAIL add16_gap: got %0d en-low cycles want 2", gl); end
            n_vec++;
            if (lc !== 1'b1) begin n_err++; $display("FAIL add16_hi_cin: got %b want 1", lc); end
            got = {result, carry, zero, negative, overflow, timeout}; want = sb.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL add16_result: got %h want %h", got, want); end
        end
        @(negedge clk);
    endtask

    task automatic test_sub16();
        bit seen; int cyc, gl; logic [7:0] lb; logic lc;
        adder_lat = 0;
        issue(2'b11, 16'h0100, 16'h0001, 0);
        await_done(80, seen, cyc, gl, lb, lc);
        n_vec++;
        if (!seen) begin n_err++; $display("FAIL sub16_done: no done"); end
        else begin
            if (lb !== 8'hFF || lc !== 1'b0) begin n_err++; $display("FAIL sub16_hi_drive: got b=%h cin=%b want ff 0", lb, lc); end
            got = {result, carry, zero, negative, overflow, timeout}; want = sb.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL sub16_result: got %h want %h", got, want); end
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        bit seen; int cyc, gl; logic [7:0] lb; logic lc;
        logic [1:0] r_op;
        for (int i = 0; i < 12; i++) begin
            adder_lat = $urandom_range(0, 3);
            r_op = 2'($urandom_range(0, 3));
            issue(r_op, 16'($urandom), 16'($urandom), 0);
            await_done(80, seen, cyc, gl, lb, lc);
            n_vec++;
            if (!seen) begin n_err++; $display("FAIL b2b_done: op %0d no done", i); end
            else begin
                got = {result, carry, zero, negative, overflow, timeout}; want = sb.pop_front();
                if (got !== want) begin n_err++; $display("FAIL b2b_result: op %0d code %0d got %h want %h", i, r_op, got, want); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_timeout();
        bit seen; int cyc, gl; logic [7:0] lb; logic lc;
        adder_stall = 1'b1;
        issue(2'b00, 16'h0011, 16'h0022, 1);
        await_done(40, seen, cyc, gl, lb, lc);
        n_vec++;
        if (!seen) begin n_err++; $display("FAIL timeout_done: no done within 40 cycles"); end
        else begin
            if (cyc !== 15) begin n_err++; $display("FAIL timeout_cycles: got %0d want 15", cyc); end
            n_vec++;
            if (adder_en !== 1'b0) begin n_err++; $display("FAIL timeout_en: got %b want 0", adder_en); end
            got = {result, carry, zero, negative, overflow, timeout}; want = sb.pop_front(); n_vec++;
            if (got !== want) begin n_err++; $display("FAIL timeout_result: got %h want %h", got, want); end
        end
        adder_stall = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_start_ignored();
        bit seen, extra; int cyc, gl; logic [7:0] lb; logic lc;
        adder_lat = 3;
        issue(2'b00, 16'd10, 16'd20, 0);
        start = 1'b1; op = 2'b11; a = 16'h1234; b = 16'h4321;
        repeat (2) @(negedge clk);
        start = 1'b0;
        await_done(50, seen, cyc, gl, lb, lc);
        n_vec++;
        if (!seen) begin n_err++; $display("FAIL busy_start_done: no done"); end
        else begin
            got = {result, carry, zero, negative, overflow, timeout}; want = sb.pop_front();
            if (got !== want) begin n_err++; $display("FAIL busy_start_result: got %h want %h", got, want); end
        end
        start = 1'b1; op = 2'b10; a = 16'h0101; b = 16'h0202;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL finish_start_busy: got %b want 0", busy); end
        extra = 1'b0;
        repeat (10) begin @(negedge clk); if (done) extra = 1'b1; end
        n_vec++;
        if (extra) begin n_err++; $display("FAIL finish_start_done: got extra done want none"); end
    endtask

    task automatic test_reset_mid();
        int ph;
        bit extra;
        adder_lat = 3;
        issue(2'b10, 16'h1111, 16'h2222, 2);
        ph = 1;
        for (int i = 0; i < 40 && ph != 3; i++) begin
            @(negedge clk);
            if (!adder_en && ph == 1) ph = 2;
            else if (adder_en && ph == 2) ph = 3;
        end
        n_vec++;
        if (ph != 3) begin n_err++; $display("FAIL reset_mid_reach: got phase %0d want 3", ph); end
        reset = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({busy, adder_en, done, result} !== 19'd0) begin
            n_err++; $display("FAIL reset_mid_state: got busy=%b en=%b done=%b res=%h want 0", busy, adder_en, done, result);
        end
        reset = 1'b0;
        last_exp = '0;
        extra = 1'b0;
        repeat (30) begin @(negedge clk); if (done) extra = 1'b1; end
        n_vec++;
        if (extra) begin n_err++; $display("FAIL reset_mid_done: got done after reset want none"); end
    endtask

    initial begin
        n_vec = 0; n_err = 0; last_exp = '0;
        adder_lat = 0; adder_stall = 1'b0;
        test_reset();
        test_add8();
        test_sub8();
        test_add16();
        test_sub16();
        test_back_to_back();
        test_timeout();
        test_start_ignored();
        test_reset_mid();
        test_timeout();
        n_vec++;
        if (sb.size() != 0) begin n_err++; $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
